// File: rtl/cv32e40s_pkg.sv
// ---------------------------------------------------------------------------
// cv32e40s_pkg
// Shared types for the data-side OBI arbiter slice:
//   data_arb_id_e      - requester identity (LSU = 0, auxiliary = 1)
//   data_arb_state_e   - arbiter FSM states (ARB, HOLD)
//   obi_data_req_t     - request payload (address, write enable, byte enables, write data)
//   obi_data_resp_t    - response payload (read data, error flag)
//   DATA_ARB_MAX_OUTSTANDING_MAX - largest legal MAX_OUTSTANDING
// ---------------------------------------------------------------------------
package cv32e40s_pkg;

  typedef enum logic {
    ARB_ID_LSU = 1'b0,
    ARB_ID_AUX = 1'b1
  } data_arb_id_e;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } data_arb_state_e;

  localparam int DATA_ARB_MAX_OUTSTANDING_MAX = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_data_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_data_resp_t;

endpackage

// File: rtl/cv32e40s_data_arb_id_fifo.sv
// ---------------------------------------------------------------------------
// cv32e40s_data_arb_id_fifo
// In-order FIFO of requester IDs for transfers that have been accepted by the
// bus but not yet answered. Responses come back in issue order, so the head
// tells the arbiter which requester the current response belongs to.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   push      - store push_id at the tail (ignored when full)
//   push_id   - ID of the accepted transfer
//   pop       - drop the head entry (ignored when empty)
//   head      - ID at the head of the FIFO
//   count     - number of stored IDs
//   empty     - count == 0
//   full      - count == DEPTH
// ---------------------------------------------------------------------------
module cv32e40s_data_arb_id_fifo
  import cv32e40s_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  data_arb_id_e       push_id,
  input  logic               pop,
  output data_arb_id_e       head,
  output logic [CNT_W-1:0]   count,
  output logic               empty,
  output logic               full
);

  data_arb_id_e     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign head    = mem[rd_ptr];

  // A pop in the same cycle does not make room for a push when full.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_id;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cv32e40s_data_obi_arbiter.sv
// ---------------------------------------------------------------------------
// cv32e40s_data_obi_arbiter
// Arbitrates two data requesters (LSU and auxiliary) onto one OBI request
// channel and routes in-order responses back to the requester that issued
// each transfer.
// Configuration macro: CV32E40S_DATA_ARB_RR_EN
//   defined   - round-robin between the two requesters
//   undefined - fixed priority, LSU over auxiliary
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   req0_valid_i/req0_ready_o/req0_i - LSU request handshake and payload
//   req1_valid_i/req1_ready_o/req1_i - auxiliary request handshake and payload
//   resp0_valid_o/resp0_o            - response to LSU
//   resp1_valid_o/resp1_o            - response to auxiliary
//   trans_valid_o/trans_ready_i/trans_o - shared request to the OBI adapter
//   resp_valid_i/resp_i              - response from the OBI adapter
//   protocol_err_o                   - response seen with nothing outstanding
// ---------------------------------------------------------------------------
module cv32e40s_data_obi_arbiter
  import cv32e40s_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid_i,
  output logic           req0_ready_o,
  input  obi_data_req_t  req0_i,
  input  logic           req1_valid_i,
  output logic           req1_ready_o,
  input  obi_data_req_t  req1_i,
  output logic           resp0_valid_o,
  output obi_data_resp_t resp0_o,
  output logic           resp1_valid_o,
  output obi_data_resp_t resp1_o,
  output logic           trans_valid_o,
  input  logic           trans_ready_i,
  output obi_data_req_t  trans_o,
  input  logic           resp_valid_i,
  input  obi_data_resp_t resp_i,
  output logic           protocol_err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  data_arb_state_e  state_q;
  data_arb_id_e     owner_q;
  data_arb_id_e     sel;
  logic             sel_valid;
  logic             push;
  logic             pop;
  data_arb_id_e     id_head;
  logic [CNT_W-1:0] id_count;
  logic             id_empty;
  logic             id_full;

`ifdef CV32E40S_DATA_ARB_RR_EN
  data_arb_id_e     last_q;
`endif

  // Pick the owner of the request channel. In HOLD the latched owner keeps
  // the channel so an unaccepted OBI request stays stable.
  always_comb begin
    sel       = ARB_ID_LSU;
    sel_valid = 1'b0;
    if (state_q == HOLD) begin
      sel       = owner_q;
      sel_valid = (owner_q == ARB_ID_LSU) ? req0_valid_i : req1_valid_i;
    end else begin
      sel_valid = req0_valid_i || req1_valid_i;
      if (req0_valid_i && req1_valid_i) begin
`ifdef CV32E40S_DATA_ARB_RR_EN
        sel = (last_q == ARB_ID_LSU) ? ARB_ID_AUX : ARB_ID_LSU;
`else
        sel = ARB_ID_LSU;
`endif
      end else if (req1_valid_i) begin
        sel = ARB_ID_AUX;
      end
    end
  end

  // New transfers are throttled once MAX_OUTSTANDING are in flight.
  assign trans_valid_o  = sel_valid && !id_full;
  assign trans_o        = !sel_valid ? '0 : ((sel == ARB_ID_AUX) ? req1_i : req0_i);
  assign push           = trans_valid_o && trans_ready_i;
  assign req0_ready_o   = push && (sel == ARB_ID_LSU);
  assign req1_ready_o   = push && (sel == ARB_ID_AUX);

  // Responses are routed with zero latency to the ID at the FIFO head.
  assign pop            = resp_valid_i && (id_count != '0);
  assign resp0_valid_o  = pop && (id_head == ARB_ID_LSU);
  assign resp1_valid_o  = pop && (id_head == ARB_ID_AUX);
  assign resp0_o        = resp0_valid_o ? resp_i : '0;
  assign resp1_o        = resp1_valid_o ? resp_i : '0;
  assign protocol_err_o = resp_valid_i && id_empty;

  // ARB/HOLD state machine; the owner is latched when a request stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
      owner_q <= ARB_ID_LSU;
    end else begin
      case (state_q)
        ARB: begin
          if (trans_valid_o && !trans_ready_i) begin
            state_q <= HOLD;
            owner_q <= sel;
          end
        end
        HOLD: begin
          if (trans_ready_i) begin
            state_q <= ARB;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

`ifdef CV32E40S_DATA_ARB_RR_EN
  // Reset to AUX so the LSU wins the first contested grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= ARB_ID_AUX;
    end else if (push) begin
      last_q <= sel;
    end
  end
`endif

  cv32e40s_data_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_id (sel),
    .pop     (pop),
    .head    (id_head),
    .count   (id_count),
    .empty   (id_empty),
    .full    (id_full)
  );

endmodule

// File: tb/tb_cv32e40s_data_obi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cv32e40s_data_obi_arbiter
// Directed bench for the data OBI arbiter. A queue-based model of the
// arbiter is compared against the DUT on every falling edge, and directed
// scenarios add hand-computed literal expectations.
// Honours CV32E40S_DATA_ARB_RR_EN for the arbitration expectations.
// ---------------------------------------------------------------------------
module tb_cv32e40s_data_obi_arbiter;
  import cv32e40s_pkg::*;

  localparam int MAX = 2;

  localparam obi_data_req_t P0 = '{addr: 32'h1000_0004, we: 1'b1, be: 4'hF, wdata: 32'hAAAA_0001};
  localparam obi_data_req_t P1 = '{addr: 32'h2000_0008, we: 1'b0, be: 4'h3, wdata: 32'h5555_0002};

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req0_valid_i = 1'b0;
  logic           req0_ready_o;
  obi_data_req_t  req0_i = P0;
  logic           req1_valid_i = 1'b0;
  logic           req1_ready_o;
  obi_data_req_t  req1_i = P1;
  logic           resp0_valid_o;
  obi_data_resp_t resp0_o;
  logic           resp1_valid_o;
  obi_data_resp_t resp1_o;
  logic           trans_valid_o;
  logic           trans_ready_i = 1'b0;
  obi_data_req_t  trans_o;
  logic           resp_valid_i = 1'b0;
  obi_data_resp_t resp_i = '0;
  logic           protocol_err_o;

  int errors = 0;
  int checks = 0;

  // Model state: queue of outstanding requester IDs, hold owner, last grant.
  int mq[$];
  bit m_hold  = 1'b0;
  int m_owner = 0;
  int m_last  = 1;

  always #5 clk = ~clk;

  cv32e40s_data_obi_arbiter #(
    .MAX_OUTSTANDING (MAX)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req0_valid_i   (req0_valid_i),
    .req0_ready_o   (req0_ready_o),
    .req0_i         (req0_i),
    .req1_valid_i   (req1_valid_i),
    .req1_ready_o   (req1_ready_o),
    .req1_i         (req1_i),
    .resp0_valid_o  (resp0_valid_o),
    .resp0_o        (resp0_o),
    .resp1_valid_o  (resp1_valid_o),
    .resp1_o        (resp1_o),
    .trans_valid_o  (trans_valid_o),
    .trans_ready_i  (trans_ready_i),
    .trans_o        (trans_o),
    .resp_valid_i   (resp_valid_i),
    .resp_i         (resp_i),
    .protocol_err_o (protocol_err_o)
  );

  task automatic checkOutput(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkWord(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester the model expects to own the channel, or -1 for none.
  function automatic int pick_sel();
    if (m_hold) begin
      if (m_owner == 0) return req0_valid_i ? 0 : -1;
      return req1_valid_i ? 1 : -1;
    end
    if (req0_valid_i && req1_valid_i) begin
`ifdef CV32E40S_DATA_ARB_RR_EN
      return (m_last == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    if (req0_valid_i) return 0;
    if (req1_valid_i) return 1;
    return -1;
  endfunction

  // Compare DUT against the model, then advance the model with the inputs
  // that the next rising edge will sample.
  always @(negedge clk) begin : cmp
    int  s;
    bit  tv;
    bit  pop;
    int  old;
    if (rst) begin
      mq.delete();
      m_hold  = 1'b0;
      m_owner = 0;
      m_last  = 1;
    end else begin
      s   = pick_sel();
      tv  = (s >= 0) && (mq.size() < MAX);
      old = mq.size();
      pop = resp_valid_i && (old > 0);
      checkOutput("m_trans_valid", trans_valid_o, tv);
      if (tv) checkWord("m_trans_o", 128'(trans_o), (s == 0) ? 128'(req0_i) : 128'(req1_i));
      checkOutput("m_req0_ready", req0_ready_o, trans_ready_i && tv && (s == 0));
      checkOutput("m_req1_ready", req1_ready_o, trans_ready_i && tv && (s == 1));
      checkOutput("m_resp0_valid", resp0_valid_o, pop && (mq[0] == 0));
      checkOutput("m_resp1_valid", resp1_valid_o, pop && (mq[0] == 1));
      if (pop) checkWord("m_resp_payload", (mq[0] == 0) ? 128'(resp0_o) : 128'(resp1_o), 128'(resp_i));
      checkOutput("m_protocol_err", protocol_err_o, resp_valid_i && (old == 0));
      if (pop) void'(mq.pop_front());
      if (tv && trans_ready_i) begin
        mq.push_back(s);
        m_last = s;
        m_hold = 1'b0;
      end else if (tv) begin
        m_hold  = 1'b1;
        m_owner = s;
      end else if (m_hold && trans_ready_i) begin
        m_hold = 1'b0;
      end
    end
  end

  // Drive one cycle of inputs just after a rising edge, then settle to
  // a point before the falling edge for literal checks.
  task automatic applyStimulus(input logic v0, input logic v1, input logic rdy,
                               input logic rv, input logic [31:0] rdata);
    @(posedge clk);
    #1;
    req0_valid_i  = v0;
    req1_valid_i  = v1;
    trans_ready_i = rdy;
    resp_valid_i  = rv;
    resp_i        = '{rdata: rdata, err: 1'b0};
    #3;
  endtask

  int g[4];

  initial begin
`ifdef CV32E40S_DATA_ARB_RR_EN
    g = '{0, 1, 0, 1};
`else
    g = '{0, 0, 0, 0};
`endif
    $display("[TB] start");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset: everything quiet.
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkOutput("rst_trans_valid", trans_valid_o, 1'b0);
    checkOutput("rst_resp0_valid", resp0_valid_o, 1'b0);
    checkOutput("rst_resp1_valid", resp1_valid_o, 1'b0);
    checkOutput("rst_protocol_err", protocol_err_o, 1'b0);

    // Both requesting, bus always ready, responses trailing by one cycle.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 1, (i > 0), 32'h100 + 32'(i));
      checkOutput("arb_req0_ready", req0_ready_o, g[i] == 0);
      checkOutput("arb_req1_ready", req1_ready_o, g[i] == 1);
      if (i > 0) begin
        checkOutput("arb_resp0_valid", resp0_valid_o, g[i-1] == 0);
        checkOutput("arb_resp1_valid", resp1_valid_o, g[i-1] == 1);
      end
    end
    applyStimulus(0, 0, 0, 1, 32'h104);
    checkOutput("arb_last_resp0", resp0_valid_o, g[3] == 0);
    checkOutput("arb_last_resp1", resp1_valid_o, g[3] == 1);

    // Stalled LSU request holds the channel against the auxiliary requester.
    applyStimulus(1, 0, 0, 0, 32'h0);
    checkWord("hold_c0_trans_o", 128'(trans_o), 128'(P0));
    checkOutput("hold_c0_req0_ready", req0_ready_o, 1'b0);
    for (int i = 1; i < 3; i++) begin
      applyStimulus(1, 1, 0, 0, 32'h0);
      checkOutput("hold_trans_valid", trans_valid_o, 1'b1);
      checkWord("hold_trans_o", 128'(trans_o), 128'(P0));
      checkOutput("hold_req1_ready", req1_ready_o, 1'b0);
    end
    applyStimulus(1, 1, 1, 0, 32'h0);
    checkOutput("hold_c3_req0_ready", req0_ready_o, 1'b1);
    checkOutput("hold_c3_req1_ready", req1_ready_o, 1'b0);
    applyStimulus(0, 1, 1, 0, 32'h0);
    checkOutput("hold_c4_req1_ready", req1_ready_o, 1'b1);
    applyStimulus(0, 0, 0, 1, 32'h200);
    checkOutput("hold_resp0_valid", resp0_valid_o, 1'b1);
    checkWord("hold_resp0_rdata", 128'(resp0_o.rdata), 128'(32'h200));
    applyStimulus(0, 0, 0, 1, 32'h201);
    checkOutput("hold_resp1_valid", resp1_valid_o, 1'b1);
    checkWord("hold_resp1_rdata", 128'(resp1_o.rdata), 128'(32'h201));

    // Outstanding limit: third request blocked until a response frees a slot.
    applyStimulus(1, 0, 1, 0, 32'h0);
    applyStimulus(1, 0, 1, 0, 32'h0);
    applyStimulus(1, 0, 1, 0, 32'h0);
    checkOutput("lim_blocked_valid", trans_valid_o, 1'b0);
    checkOutput("lim_blocked_ready", req0_ready_o, 1'b0);
    applyStimulus(1, 0, 1, 1, 32'h300);
    checkOutput("lim_resp_routed", resp0_valid_o, 1'b1);
    checkOutput("lim_same_cycle_valid", trans_valid_o, 1'b0);
    applyStimulus(1, 0, 1, 0, 32'h0);
    checkOutput("lim_reassert_valid", trans_valid_o, 1'b1);
    checkOutput("lim_reassert_ready", req0_ready_o, 1'b1);
    applyStimulus(0, 0, 0, 1, 32'h301);
    applyStimulus(0, 0, 0, 1, 32'h302);
    checkOutput("lim_drain_resp0", resp0_valid_o, 1'b1);

    // In-order routing for IDs 0, 1, 1.
    applyStimulus(1, 0, 1, 0, 32'h0);
    applyStimulus(0, 1, 1, 0, 32'h0);
    applyStimulus(0, 1, 1, 1, 32'h400);
    checkOutput("ord_r0_resp0", resp0_valid_o, 1'b1);
    checkOutput("ord_r0_resp1", resp1_valid_o, 1'b0);
    checkWord("ord_r0_rdata", 128'(resp0_o.rdata), 128'(32'h400));
    applyStimulus(0, 1, 1, 1, 32'h401);
    checkOutput("ord_r1_resp1", resp1_valid_o, 1'b1);
    checkOutput("ord_r1_req1_ready", req1_ready_o, 1'b1);
    checkWord("ord_r1_rdata", 128'(resp1_o.rdata), 128'(32'h401));
    applyStimulus(0, 0, 0, 1, 32'h402);
    checkOutput("ord_r2_resp1", resp1_valid_o, 1'b1);
    checkOutput("ord_r2_resp0", resp0_valid_o, 1'b0);
    checkWord("ord_r2_rdata", 128'(resp1_o.rdata), 128'(32'h402));

    // Spurious response with nothing outstanding.
    applyStimulus(0, 0, 0, 1, 32'h500);
    checkOutput("err_pulse", protocol_err_o, 1'b1);
    checkOutput("err_no_resp0", resp0_valid_o, 1'b0);
    checkOutput("err_no_resp1", resp1_valid_o, 1'b0);
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkOutput("err_cleared", protocol_err_o, 1'b0);

    // Reset with two outstanding discards them.
    applyStimulus(1, 0, 1, 0, 32'h0);
    applyStimulus(1, 0, 1, 0, 32'h0);
    @(posedge clk);
    #1;
    rst           = 1'b1;
    req0_valid_i  = 1'b0;
    req1_valid_i  = 1'b0;
    trans_ready_i = 1'b0;
    resp_valid_i  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(0, 0, 0, 1, 32'h600);
    checkOutput("rstmid_err", protocol_err_o, 1'b1);
    checkOutput("rstmid_no_resp0", resp0_valid_o, 1'b0);
    applyStimulus(1, 0, 1, 0, 32'h0);
    checkOutput("rstmid_count_free", trans_valid_o, 1'b1);
    applyStimulus(0, 0, 0, 1, 32'h601);
    checkOutput("rstmid_drain_resp0", resp0_valid_o, 1'b1);
    applyStimulus(0, 0, 0, 0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cv32e40s_data_obi_arbiter.md
CV32E40S_DATA_OBI_ARBITER -- requirements
Module: cv32e40s_data_obi_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, meaning maximum accepted-but-unanswered transfers (1..8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid_i input 1, req0_ready_o output 1, req0_i input obi_data_req_t: requester 0 (LSU) transaction request.
REQ-005 SHALL have ports req1_valid_i input 1, req1_ready_o output 1, req1_i input obi_data_req_t: requester 1 (auxiliary) transaction request.
REQ-006 SHALL have ports resp0_valid_o output 1, resp0_o output obi_data_resp_t: response to requester 0; same for resp1_valid_o/resp1_o.
REQ-007 SHALL have ports trans_valid_o output 1, trans_ready_i input 1, trans_o output obi_data_req_t: shared request towards the data OBI adapter.
REQ-008 SHALL have ports resp_valid_i input 1, resp_i input obi_data_resp_t: response from the data OBI adapter.
REQ-009 SHALL have port protocol_err_o  output  1  single-cycle pulse on a response arriving with no outstanding transfer.

Function
REQ-010 SHALL implement states ARB and HOLD; reset state ARB.
REQ-011 In ARB, SHALL select among valid requesters per REQ-020/021; trans_valid_o = selected valid AND (count < MAX_OUTSTANDING); trans_o = selected payload, combinationally.
REQ-012 ARB -> HOLD when trans_valid_o=1 and trans_ready_i=0; owner latched.
REQ-013 In HOLD, SHALL keep the latched owner regardless of the other requester; HOLD -> ARB on trans_ready_i=1.
REQ-014 reqN_ready_o SHALL equal trans_ready_i AND trans_valid_o AND owner==N; the non-owner sees ready=0.
REQ-015 Accepted transfer (trans_valid_o & trans_ready_i) SHALL push the owner ID into an in-order ID FIFO and increment count.
REQ-016 resp_valid_i with count>0 SHALL pop the FIFO head, drive respN_valid_o=1 and respN_o=resp_i for N=head ID in the same cycle (zero latency), and decrement count.
REQ-017 Simultaneous push and pop SHALL leave count unchanged and preserve order, including when count==MAX_OUTSTANDING (the pop does not free the slot until the next cycle).
REQ-018 resp_valid_i with count==0 SHALL pulse protocol_err_o for one cycle, leave FIFO/count unchanged, and keep both respN_valid_o=0.
REQ-019 count width SHALL be $clog2(MAX_OUTSTANDING+1); FIFO pointers SHALL wrap modulo MAX_OUTSTANDING.
REQ-020 Without the macro of REQ-026: fixed priority, requester 0 over requester 1.
REQ-021 With the macro: round-robin; when both valid, grant the requester not granted last; last-grant pointer updates only on an accepted transfer.
REQ-022 Requesters SHALL NOT be required to hold valid while ungranted; the owner in HOLD is required by OBI to hold valid and payload stable.

Reset
REQ-023 On rst=1 at a clock edge: state ARB, count 0, FIFO pointers 0, last-grant pointer = 1 (requester 0 wins first).
REQ-024 While count==0 after reset, all outputs SHALL be 0 except combinational pass-through of a valid request (trans_valid_o, trans_o, reqN_ready_o).
REQ-025 Reset asserted mid-transfer SHALL discard all outstanding IDs; late responses then raise protocol_err_o.

Configuration
REQ-026 Macro CV32E40S_DATA_ARB_RR_EN: defined selects round-robin arbitration (REQ-021); undefined selects fixed priority (REQ-020); no other behaviour changes.

Structure
REQ-027 cv32e40s_pkg SHALL hold typedef data_arb_id_e (ARB_ID_LSU=0, ARB_ID_AUX=1) and constant DATA_ARB_MAX_OUTSTANDING_MAX=8.
REQ-028 The ID FIFO SHALL be sub-module cv32e40s_data_arb_id_fifo (push, pop, head, count, empty, full).

Verification
REQ-029 Both valid at reset, trans_ready_i=1 -> req0 granted cycle 0; fixed: req0 every cycle; RR: grants 0,1,0,1.
REQ-030 req0 valid, trans_ready_i=0 for 3 cycles, req1 asserted in cycle 1 -> trans_o stays req0 payload, req1_ready_o=0, state HOLD until cycle 3.
REQ-031 MAX_OUTSTANDING=2, 2 accepted, no response -> trans_valid_o=0; response plus new request in the same cycle -> response routed, trans_valid_o reasserts the next cycle.
REQ-032 Issue ids 0,1,1 then 3 responses -> resp0_valid_o, resp1_valid_o, resp1_valid_o in order, payloads equal resp_i.
REQ-033 resp_valid_i=1 with count 0 -> protocol_err_o=1 for exactly one cycle, no respN_valid_o.
REQ-034 rst=1 with 2 outstanding, then response -> count 0 after reset, protocol_err_o=1.
